cache_mem_ctrl: RTL and testbench



---
 rtl/cache_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 38 +++
 rtl/cache_mem_ctrl.sv | 125 ++++++++++++
 tb/tb_cache_mem_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache-to-memory sequencer.
package cache_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {IDLE, BUS, FILL, HALT} ctrl_state_t;

  typedef enum logic {OWN_I, OWN_D} owner_t;

  // The wait counter is never narrower than 8 bits and always wide
  // enough to hold TIMEOUT, so it cannot wrap before the compare.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter for the I and D request lines.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_i,
  input  logic req_d,
  output logic gnt_i,
  output logic gnt_d
);

  logic prio_i;

  // Grant the single requester, or the side owed a turn when both ask.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (en) begin
      if (req_i && req_d) begin
        gnt_i = prio_i;
        gnt_d = !prio_i;
      end else begin
        gnt_i = req_i;
        gnt_d = req_d;
      end
    end
  end

  // Priority flips only on contested grants; reset favours D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_i <= 1'b0;
    end else if (en && req_i && req_d) begin
      prio_i <= !prio_i;
    end
  end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Arbiter and sequencer for the main-memory port shared by I$ and D$.
//
// state | meaning
// IDLE  | sample requests, grant one side, latch its transaction
// BUS   | mem_req held with stable address/data until mem_ready
// FILL  | one-cycle fill/ack strobe to the owning cache
// HALT  | memory timed out; parked until reset
module cache_mem_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_miss,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              i_fill,
  output logic              d_fill,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_stall,
  output logic              d_stall,
  output logic              timeout_err
);

  localparam int               CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  ctrl_state_t       state, state_nxt;
  owner_t            owner_q;
  logic              we_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              gnt_i, gnt_d, grant;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == IDLE),
    .req_i (i_miss),
    .req_d (d_miss),
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );

  assign grant = gnt_i || gnt_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and decoded outputs; mem_ready only matters in BUS.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    i_fill    = 1'b0;
    d_fill    = 1'b0;
    case (state)
      IDLE: if (grant) state_nxt = BUS;
      BUS: begin
        mem_req = 1'b1;
        if (mem_ready)                  state_nxt = FILL;
        else if (wait_cnt == CNT_LAST)  state_nxt = HALT;
      end
      FILL: begin
        i_fill    = (owner_q == OWN_I);
        d_fill    = (owner_q == OWN_D);
        state_nxt = IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_we  = mem_req && we_q;
  assign i_stall = i_miss && !i_fill;
  assign d_stall = d_miss && !d_fill;

  // Capture the granted transaction so the bus stays stable even if the
  // requester misbehaves and drops its line early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_D;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE && grant) begin
      owner_q   <= gnt_d ? OWN_D : OWN_I;
      we_q      <= gnt_d && d_we;
      mem_addr  <= gnt_d ? d_addr : i_addr;
      mem_wdata <= (gnt_d && d_we) ? d_wdata : '0;
    end
  end

  // Completion data, wait counter and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_data   <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (state == BUS) begin
      if (mem_ready) begin
        fill_data <= we_q ? '0 : mem_rdata;
        wait_cnt  <= '0;
      end else if (wait_cnt == CNT_LAST) begin
        timeout_err <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl with an expected-fill scoreboard.
module tb_cache_mem_ctrl;

  localparam logic [31:0] KEY = 32'hDEADBFEF;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        mem_req, mem_we, i_fill, d_fill, i_stall, d_stall, timeout_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, fill_data;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Memory read model: data is a fixed function of the address.
  assign mem_rdata = mem_addr ^ KEY;

  cache_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .i_fill(i_fill), .d_fill(d_fill), .fill_data(fill_data),
    .i_stall(i_stall), .d_stall(d_stall), .timeout_err(timeout_err)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    sb.push_back(e);
  endtask

  // Compare a fill strobe seen now against the oldest expectation.
  task automatic take_fill();
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("fill_onehot", 32'(i_fill && d_fill), 0);
    chk("fill_owner", 32'(d_fill), 32'(e.is_d));
    chk("fill_data", fill_data, e.data);
    if (d_fill) d_miss = 1'b0;
    else        i_miss = 1'b0;
  endtask

  task automatic wait_fill(input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (i_fill || d_fill) begin
        take_fill();
        got = 1'b1;
      end
    end
    chk("fill_seen", 32'(got), 1);
  endtask

  initial begin
    rst_n = 1'b0; i_miss = 1'b0; d_miss = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    #3;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_outs", 32'({mem_we, i_fill, d_fill, timeout_err}), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fill_data", fill_data, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single I miss with zero-wait memory.
    mem_ready = 1'b1;
    @(negedge clk);
    i_miss = 1'b1; i_addr = 32'h100;
    push(1'b0, 32'hDEADBEEF);
    #1;
    chk("c0_i_stall", 32'(i_stall), 1);
    chk("c0_mem_req", 32'(mem_req), 0);
    @(negedge clk);
    chk("c1_mem_req", 32'(mem_req), 1);
    chk("c1_mem_addr", mem_addr, 32'h100);
    chk("c1_mem_we", 32'(mem_we), 0);
    chk("c1_i_stall", 32'(i_stall), 1);
    @(negedge clk);
    chk("c2_i_fill", 32'(i_fill), 1);
    chk("c2_i_stall", 32'(i_stall), 0);
    take_fill();
    @(negedge clk);
    chk("c3_no_fill", 32'({i_fill, d_fill}), 0);
    chk("c3_mem_req", 32'(mem_req), 0);

    // Collision from reset priority: D then I.
    i_miss = 1'b1; i_addr = 32'h200;
    d_miss = 1'b1; d_addr = 32'h300; d_we = 1'b0;
    push(1'b1, rd(32'h300));
    push(1'b0, rd(32'h200));
    wait_fill(6);
    wait_fill(6);

    // Repeated collision: I now wins.
    @(negedge clk);
    i_miss = 1'b1; i_addr = 32'h400;
    d_miss = 1'b1; d_addr = 32'h500;
    push(1'b0, rd(32'h400));
    push(1'b1, rd(32'h500));
    wait_fill(6);
    wait_fill(6);

    // D store with three wait cycles.
    @(negedge clk);
    mem_ready = 1'b0;
    d_miss = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
    push(1'b1, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("st_mem_req", 32'(mem_req), 1);
      chk("st_mem_we", 32'(mem_we), 1);
      chk("st_mem_addr", mem_addr, 32'h20);
      chk("st_mem_wdata", mem_wdata, 32'h55);
      chk("st_d_stall", 32'(d_stall), 1);
      chk("st_no_fill", 32'(d_fill), 0);
    end
    @(negedge clk);
    chk("st_hold_addr", mem_addr, 32'h20);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("st_d_fill", 32'(d_fill), 1);
    if (d_fill) take_fill();
    d_miss = 1'b0; d_we = 1'b0;

    // Memory never answers: timeout after four BUS cycles.
    @(negedge clk);
    mem_ready = 1'b0;
    d_miss = 1'b1; d_addr = 32'h40;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("to_mem_req", 32'(mem_req), 1);
      chk("to_err_low", 32'(timeout_err), 0);
    end
    @(negedge clk);
    chk("to_err_set", 32'(timeout_err), 1);
    chk("to_req_drop", 32'(mem_req), 0);
    chk("to_d_stall", 32'(d_stall), 1);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 32'(timeout_err), 1);
    chk("to_no_fill", 32'({i_fill, d_fill}), 0);
    chk("to_halt_req", 32'(mem_req), 0);
    rst_n = 1'b0;
    d_miss = 1'b0;
    #1;
    chk("to_err_clear", 32'(timeout_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset pulse during BUS, then a fresh request.
    mem_ready = 1'b0;
    @(negedge clk);
    i_miss = 1'b1; i_addr = 32'h600;
    @(negedge clk);
    chk("rb_mem_req", 32'(mem_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_req_drop", 32'(mem_req), 0);
    chk("rb_addr_clr", mem_addr, 0);
    i_miss = 1'b0;
    @(negedge clk);
    chk("rb_no_fill", 32'({i_fill, d_fill}), 0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rb_idle", 32'({mem_req, i_fill, d_fill}), 0);
    i_miss = 1'b1; i_addr = 32'h700;
    push(1'b0, rd(32'h700));
    wait_fill(6);

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
